bcd_display_scan: RTL and testbench

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_display_scan_pkg.sv | 25 ++
 rtl/bcd_display_scan_bcd_to_seg7.sv | 32 +++
 rtl/bcd_display_scan.sv | 108 ++++++++++
 tb/tb_bcd_display_scan.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_display_scan_pkg                                            |
// | Purpose  : Shared BCD digit type and seven-segment patterns (gfedcba, low). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package bcd_display_scan_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/bcd_display_scan_bcd_to_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_to_seg7                                                     |
// | Purpose  : Combinational BCD nibble to active-low segment decoder.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bcd_to_seg7
  import bcd_display_scan_pkg::*;
(
  input  digit_t     i_digit,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_DASH;
    case (i_digit)
      4'd0:    o_seg_n = SEG_0;
      4'd1:    o_seg_n = SEG_1;
      4'd2:    o_seg_n = SEG_2;
      4'd3:    o_seg_n = SEG_3;
      4'd4:    o_seg_n = SEG_4;
      4'd5:    o_seg_n = SEG_5;
      4'd6:    o_seg_n = SEG_6;
      4'd7:    o_seg_n = SEG_7;
      4'd8:    o_seg_n = SEG_8;
      4'd9:    o_seg_n = SEG_9;
      default: o_seg_n = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bcd_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_display_scan                                                |
// | Purpose  : Multiplexed BCD seven-segment scanner with shadow latch and     |
// |            sticky illegal-digit flag. BCD_SCAN_LZ_BLANK_EN enables         |
// |            leading-zero blanking.                                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [6:0]              r_seg_n;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic                    r_err;

  digit_t                  w_digit;
  logic [6:0]              w_seg_dec;
  logic [NUM_DIGITS-1:0]   w_bad;
  logic                    w_lz_blank;
  logic                    w_blank;

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_bad
      assign w_bad[g] = (r_shadow[4*g +: 4] > 4'd9);
    end
  endgenerate

`ifdef BCD_SCAN_LZ_BLANK_EN
  // w_upper_zero[g]: nibble g and every nibble above it are zero.
  logic [NUM_DIGITS-1:0] w_upper_zero;
  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
      if (g == NUM_DIGITS - 1) begin : g_top
        assign w_upper_zero[g] = (r_shadow[4*g +: 4] == 4'd0);
      end else begin : g_mid
        assign w_upper_zero[g] = (r_shadow[4*g +: 4] == 4'd0) && w_upper_zero[g+1];
      end
    end
  endgenerate
  assign w_lz_blank = (r_idx != '0) && w_upper_zero[r_idx];
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_digit = r_shadow[4*int'(r_idx) +: 4];
  assign w_blank = (r_cnt == '0) || w_lz_blank;

  bcd_to_seg7 u_dec (
    .i_digit (w_digit),
    .o_seg_n (w_seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_seg_n  <= SEG_BLANK;
      r_an_n   <= '1;
      r_err    <= 1'b0;
    end else begin
      if (load) begin
        r_shadow <= digits_in;
      end
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_err <= r_err | (|w_bad);
      // Outputs trail the scan state by one cycle; blank slots gate both buses.
      if (w_blank) begin
        r_seg_n <= SEG_BLANK;
        r_an_n  <= '1;
      end else begin
        r_seg_n <= w_seg_dec;
        r_an_n  <= ~(NUM_DIGITS'(1) << r_idx);
      end
    end
  end

  assign seg_n = r_seg_n;
  assign an_n  = r_an_n;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bcd_display_scan                                             |
// | Purpose  : Self-checking bench: vector table, directed corners and random  |
// |            stimulus against an arithmetic reference model.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bcd_display_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            load = 1'b0;
  logic [15:0]     digits_in = '0;
  logic [6:0]      seg_n;
  logic [ND-1:0]   an_n;
  logic            err;

  bcd_display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .digits_in (digits_in),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] segtab [16];

  int          m_n      = 0;
  logic [15:0] m_shadow = '0;
  logic        m_err    = 1'b0;
  logic        m_valid  = 1'b0;
  logic [6:0]  exp_seg  = 7'h7F;
  logic [3:0]  exp_an   = 4'hF;

  typedef struct {
    logic        r;
    logic        l;
    logic [15:0] d;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        e;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Display state is a pure function of edges since reset: count = n mod RD, slot = n / RD.
  task automatic model_out();
    int cnt, idx, nib;
    bit blank;
    cnt   = m_n % RD;
    idx   = (m_n / RD) % ND;
    nib   = int'((m_shadow >> (4 * idx)) & 16'hF);
    blank = (cnt == 0);
`ifdef BCD_SCAN_LZ_BLANK_EN
    if (idx > 0 && (m_shadow >> (4 * idx)) == 16'h0) blank = 1'b1;
`endif
    exp_an  = blank ? 4'hF : ~(4'(1) << idx);
    exp_seg = blank ? 7'h7F : segtab[nib];
  endtask

  function automatic logic any_illegal(input logic [15:0] v);
    logic r = 1'b0;
    for (int i = 0; i < ND; i++) if (((v >> (4 * i)) & 16'hF) > 16'd9) r = 1'b1;
    return r;
  endfunction

  task automatic step(input logic r, input logic l, input logic [15:0] d);
    rstn = r; load = l; digits_in = d;
    if (!r) begin
      exp_seg = 7'h7F; exp_an = 4'hF; m_err = 1'b0;
      m_n = 0; m_shadow = '0; m_valid = 1'b1;
    end else begin
      model_out();
      m_err = m_err | any_illegal(m_shadow);
      m_n++;
      if (l) m_shadow = d;
    end
    @(posedge clk);
    @(negedge clk);
    if (m_valid) begin
      chk("model_seg", 32'(seg_n), 32'(exp_seg));
      chk("model_an",  32'(an_n),  32'(exp_an));
      chk("model_err", 32'(err),   32'(m_err));
    end
  endtask

  task automatic add(input logic r, input logic l, input logic [15:0] d,
                     input logic [6:0] seg, input logic [3:0] an);
    vec_t v;
    v.r = r; v.l = l; v.d = d; v.seg = seg; v.an = an; v.e = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic add_slot(input logic [6:0] seg, input logic [3:0] an);
    add(1'b1, 1'b0, 16'h0, 7'h7F, 4'hF);
    repeat (3) add(1'b1, 1'b0, 16'h0, seg, an);
  endtask

  task automatic do_reset();
    repeat (3) step(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) segtab[i] = 7'b0111111;

    // Reset for three cycles, then load 1234 and scan one full frame.
    repeat (3) add(1'b0, 1'b0, 16'h0, 7'h7F, 4'hF);
    add(1'b1, 1'b1, 16'h1234, 7'h7F, 4'hF);
    repeat (3) add(1'b1, 1'b0, 16'h0, 7'b0011001, 4'b1110);
    add_slot(7'b0110000, 4'b1101);
    add_slot(7'b0100100, 4'b1011);
    add_slot(7'b1111001, 4'b0111);
    add(1'b1, 1'b0, 16'h0, 7'h7F, 4'hF);
    add(1'b1, 1'b0, 16'h0, 7'b0011001, 4'b1110);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].l, vecs[i].d);
      chk("vec_seg", 32'(seg_n), 32'(vecs[i].seg));
      chk("vec_an",  32'(an_n),  32'(vecs[i].an));
      chk("vec_err", 32'(err),   32'(vecs[i].e));
    end

    // Illegal nibble then a legal reload: err stays sticky.
    do_reset();
    step(1'b1, 1'b1, 16'h000A);
    chk("ill_err_lag", 32'(err), 32'd0);
    step(1'b1, 1'b0, 16'h0);
    chk("ill_dash", 32'(seg_n), 32'b0111111);
    chk("ill_an",   32'(an_n),  32'b1110);
    chk("ill_err",  32'(err),   32'd1);
    step(1'b1, 1'b1, 16'h0005);
    step(1'b1, 1'b0, 16'h0);
    chk("reload_seg", 32'(seg_n), 32'b0010010);
    chk("reload_err", 32'(err),   32'd1);

    // Leading zeros with 0070.
    do_reset();
    step(1'b1, 1'b1, 16'h0070);
    for (int j = 1; j <= 13; j++) begin
      step(1'b1, 1'b0, 16'h0);
      if (j == 1) begin
        chk("lz_s0_seg", 32'(seg_n), 32'b1000000);
        chk("lz_s0_an",  32'(an_n),  32'b1110);
      end else if (j == 5) begin
        chk("lz_s1_seg", 32'(seg_n), 32'b1111000);
        chk("lz_s1_an",  32'(an_n),  32'b1101);
      end else if (j == 9 || j == 13) begin
`ifdef BCD_SCAN_LZ_BLANK_EN
        chk("lz_hi_seg", 32'(seg_n), 32'h7F);
        chk("lz_hi_an",  32'(an_n),  32'hF);
`else
        chk("lz_hi_seg", 32'(seg_n), 32'b1000000);
        chk("lz_hi_an",  32'(an_n),  (j == 9) ? 32'b1011 : 32'b0111);
`endif
      end
    end

    // Mid-scan reset during slot 2.
    do_reset();
    step(1'b1, 1'b1, 16'h1234);
    for (int j = 1; j <= 9; j++) step(1'b1, 1'b0, 16'h0);
    chk("mid_pre_an", 32'(an_n), 32'b1011);
    step(1'b0, 1'b0, 16'h0);
    chk("mid_rst_seg", 32'(seg_n), 32'h7F);
    chk("mid_rst_an",  32'(an_n),  32'hF);
    step(1'b1, 1'b0, 16'h0);
    chk("mid_blank_an", 32'(an_n), 32'hF);
    step(1'b1, 1'b0, 16'h0);
    chk("mid_s0_an",  32'(an_n),  32'b1110);
    chk("mid_s0_seg", 32'(seg_n), 32'b1000000);

    // Load coinciding with the advance to slot 1.
    do_reset();
    repeat (3) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h9999);
    step(1'b1, 1'b0, 16'h0);
    chk("bnd_blank_an", 32'(an_n), 32'hF);
    step(1'b1, 1'b0, 16'h0);
    chk("bnd_s1_an",  32'(an_n),  32'b1101);
    chk("bnd_s1_seg", 32'(seg_n), 32'b0010000);

    // Random traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] d;
      d = '0;
      for (int i = 0; i < ND; i++) begin
        case ($urandom_range(0, 3))
          0:       d[4*i +: 4] = 4'd0;
          3:       d[4*i +: 4] = 4'($urandom_range(0, 15));
          default: d[4*i +: 4] = 4'($urandom_range(0, 9));
        endcase
      end
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0), d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
